// File: rtl/spi_oled_receiver.sv
// SPI mode-0 slave modelling an SSD1306-style OLED controller: oversampled byte
// assembly, page/column command decode and page-addressing GDDRAM writes.
module spi_oled_receiver #(
    parameter int COLS   = 128,
    parameter int PAGES  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    input  logic              spi_cs_n,
    input  logic              spi_dc,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              cmd_valid,
    output logic [7:0]        cmd_byte,
    output logic              display_on,
    output logic [2:0]        page,
    output logic [6:0]        col,
    output logic              frame_err,
    output logic [15:0]       byte_count
);

    logic              r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic              r_mosi_s1, r_mosi_s2;
    logic              r_dc_s1, r_dc_s2;
    logic              r_cs_s1, r_cs_s2, r_cs_s3;
    logic [6:0]        r_shreg;
    logic [2:0]        r_bit_cnt;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [7:0]        r_ram_wdata;
    logic              r_cmd_valid;
    logic [7:0]        r_cmd_byte;
    logic              r_display_on;
    logic [2:0]        r_page;
    logic [6:0]        r_col;
    logic              r_frame_err;
    logic [15:0]       r_byte_count;

    logic              w_rise;
    logic              w_cs_rise;
    logic              w_active;
    logic [7:0]        w_byte;
    logic [ADDR_W-1:0] w_addr;

    assign w_rise    = r_sclk_s2 & ~r_sclk_s3;
    assign w_cs_rise = r_cs_s2 & ~r_cs_s3;
    // A clock rise coinciding with cs_n rising still belongs to the transfer
    assign w_active  = ~r_cs_s2 | w_cs_rise;
    assign w_byte    = {r_shreg, r_mosi_s2};
    assign w_addr    = ADDR_W'(r_page) * ADDR_W'(COLS) + ADDR_W'(r_col);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_s1    <= 1'b0;
            r_sclk_s2    <= 1'b0;
            r_sclk_s3    <= 1'b0;
            r_mosi_s1    <= 1'b0;
            r_mosi_s2    <= 1'b0;
            r_dc_s1      <= 1'b0;
            r_dc_s2      <= 1'b0;
            r_cs_s1      <= 1'b0;
            r_cs_s2      <= 1'b0;
            r_cs_s3      <= 1'b0;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_cmd_valid  <= 1'b0;
            r_cmd_byte   <= '0;
            r_display_on <= 1'b0;
            r_page       <= '0;
            r_col        <= '0;
            r_frame_err  <= 1'b0;
            r_byte_count <= '0;
        end else begin
            r_sclk_s1   <= spi_clk;
            r_sclk_s2   <= r_sclk_s1;
            r_sclk_s3   <= r_sclk_s2;
            r_mosi_s1   <= spi_mosi;
            r_mosi_s2   <= r_mosi_s1;
            r_dc_s1     <= spi_dc;
            r_dc_s2     <= r_dc_s1;
            r_cs_s1     <= spi_cs_n;
            r_cs_s2     <= r_cs_s1;
            r_cs_s3     <= r_cs_s2;
            r_ram_we    <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_rise && w_active) begin
                r_shreg <= {r_shreg[5:0], r_mosi_s2};
                if (r_bit_cnt == 3'd7) begin
                    r_bit_cnt    <= '0;
                    r_byte_count <= r_byte_count + 16'd1;
                    if (r_dc_s2) begin
                        r_ram_we    <= 1'b1;
                        r_ram_addr  <= w_addr;
                        r_ram_wdata <= w_byte;
                        r_col       <= (r_col == 7'(COLS - 1)) ? '0 : r_col + 7'd1;
                    end else begin
                        r_cmd_valid <= 1'b1;
                        r_cmd_byte  <= w_byte;
                        if (w_byte[7:3] == 5'b10110) begin
                            if (int'(w_byte[2:0]) < PAGES)
                                r_page <= w_byte[2:0];
                        end else if (w_byte[7:4] == 4'h0) begin
                            r_col[3:0] <= w_byte[3:0];
                        end else if (w_byte[7:3] == 5'b00010) begin
                            r_col[6:4] <= w_byte[2:0];
                        end else if (w_byte == 8'hAF) begin
                            r_display_on <= 1'b1;
                        end else if (w_byte == 8'hAE) begin
                            r_display_on <= 1'b0;
                        end
                    end
                end else if (w_cs_rise) begin
                    r_frame_err <= 1'b1;
                    r_bit_cnt   <= '0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end else if (w_cs_rise && (r_bit_cnt != 3'd0)) begin
                r_frame_err <= 1'b1;
                r_bit_cnt   <= '0;
            end
        end
    end

    assign ram_we     = r_ram_we;
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;
    assign cmd_valid  = r_cmd_valid;
    assign cmd_byte   = r_cmd_byte;
    assign display_on = r_display_on;
    assign page       = r_page;
    assign col        = r_col;
    assign frame_err  = r_frame_err;
    assign byte_count = r_byte_count;

endmodule

// File: tb/tb_spi_oled_receiver.sv
// Directed bench for spi_oled_receiver: reset, addressing, wrap, framing, latency.
`timescale 1ns/1ps
module tb_spi_oled_receiver;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_clk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_dc = 1'b0;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        display_on;
    logic [2:0]  page;
    logic [6:0]  col;
    logic        frame_err;
    logic [15:0] byte_count;

    int tests = 0;
    int fails = 0;
    int exp_bc = 0;
    int we_cnt = 0;
    int cmd_cnt = 0;
    int fe_cnt = 0;
    logic [9:0] wa_q[$];
    logic [7:0] wd_q[$];

    spi_oled_receiver #(.COLS(128), .PAGES(8), .ADDR_W(10)) dut (
        .clk(clk), .reset_n(reset_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n), .spi_dc(spi_dc), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
        .display_on(display_on), .page(page), .col(col), .frame_err(frame_err),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_we) begin
            we_cnt++;
            wa_q.push_back(ram_addr);
            wd_q.push_back(ram_wdata);
        end
        if (cmd_valid) cmd_cnt++;
        if (frame_err) fe_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    // Sends n bits MSB first; e/l hold ram_we 2 and 3 clk edges after the last raw rise
    task automatic send_bits(input logic [7:0] b, input int n, input logic dc, input int half,
                             input bit raise_cs, output logic e, output logic l);
        e = 1'b0;
        l = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            spi_clk = 1'b0; spi_mosi = b[7-i]; spi_dc = dc;
            repeat (half) @(posedge clk);
            #1;
            spi_clk = 1'b1;
            if (raise_cs && i == n - 1) spi_cs_n = 1'b1;
            repeat (2) @(posedge clk);
            #1; e = ram_we;
            @(posedge clk);
            #1; l = ram_we;
            repeat (half - 3) @(posedge clk);
        end
        @(posedge clk); #1;
        spi_clk = 1'b0;
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        logic e, l;
        send_bits(b, 8, 1'b0, 4, 1'b0, e, l);
        exp_bc++;
        settle();
    endtask

    task automatic send_data(input logic [7:0] b);
        logic e, l;
        send_bits(b, 8, 1'b1, 4, 1'b0, e, l);
        exp_bc++;
        settle();
    endtask

    task automatic test_reset();
        logic e, l;
        int f0, c0;
        repeat (5) @(posedge clk);
        #1; reset_n = 1'b1;
        settle();
        spi_cs_n = 1'b0;
        settle();
        send_bits(8'hE0, 3, 1'b1, 4, 1'b0, e, l);
        f0 = fe_cnt;
        reset_n = 1'b0;
        #1000;
        reset_n = 1'b1;
        settle();
        tests++; if (fe_cnt !== f0) begin fails++; $display("FAIL reset_frame_err: count %0d, required %0d", fe_cnt, f0); end
        tests++; if (we_cnt !== 0 || cmd_cnt !== 0) begin fails++; $display("FAIL reset_strobes: we %0d cmd %0d, required 0 0", we_cnt, cmd_cnt); end
        tests++; if ({ram_we, ram_addr, ram_wdata, cmd_valid, cmd_byte, display_on, page, col, frame_err} !== '0)
            begin fails++; $display("FAIL reset_outputs: addr %0h wdata %0h cmd %0h page %0d col %0d, required all 0", ram_addr, ram_wdata, cmd_byte, page, col); end
        tests++; if (byte_count !== 16'd0) begin fails++; $display("FAIL reset_byte_count: got %0d, required 0", byte_count); end
        c0 = cmd_cnt;
        send_cmd(8'hAF);
        tests++; if (cmd_cnt - c0 !== 1) begin fails++; $display("FAIL af_cmd_valid: pulses %0d, required 1", cmd_cnt - c0); end
        tests++; if (cmd_byte !== 8'hAF) begin fails++; $display("FAIL af_cmd_byte: got %0h, required af", cmd_byte); end
        tests++; if (display_on !== 1'b1) begin fails++; $display("FAIL af_display_on: got %0b, required 1", display_on); end
        tests++; if (byte_count !== 16'd1) begin fails++; $display("FAIL af_byte_count: got %0d, required 1", byte_count); end
    endtask

    task automatic test_addressing();
        int w0;
        send_cmd(8'hB3);
        send_cmd(8'h05);
        send_cmd(8'h12);
        tests++; if (page !== 3'd3) begin fails++; $display("FAIL addr_page: got %0d, required 3", page); end
        tests++; if (col !== 7'h25) begin fails++; $display("FAIL addr_col_pre: got %0h, required 25", col); end
        w0 = we_cnt;
        send_data(8'hA5);
        tests++; if (we_cnt - w0 !== 1) begin fails++; $display("FAIL addr_we_count: got %0d, required 1", we_cnt - w0); end
        else begin
            tests++; if (wa_q[w0] !== 10'd421) begin fails++; $display("FAIL addr_ram_addr: got %0d, required 421", wa_q[w0]); end
            tests++; if (wd_q[w0] !== 8'hA5) begin fails++; $display("FAIL addr_ram_wdata: got %0h, required a5", wd_q[w0]); end
        end
        tests++; if (col !== 7'd38) begin fails++; $display("FAIL addr_col_post: got %0d, required 38", col); end
        tests++; if (byte_count !== 16'(exp_bc)) begin fails++; $display("FAIL addr_byte_count: got %0d, required %0d", byte_count, exp_bc); end
    endtask

    task automatic test_misc_cmds();
        int c0;
        c0 = cmd_cnt;
        send_cmd(8'h81);
        send_cmd(8'h1A);
        tests++; if (cmd_cnt - c0 !== 2) begin fails++; $display("FAIL misc_cmd_valid: pulses %0d, required 2", cmd_cnt - c0); end
        tests++; if (cmd_byte !== 8'h1A) begin fails++; $display("FAIL misc_cmd_byte: got %0h, required 1a", cmd_byte); end
        tests++; if (page !== 3'd3 || col !== 7'd38 || display_on !== 1'b1)
            begin fails++; $display("FAIL misc_state: page %0d col %0d disp %0b, required 3 38 1", page, col, display_on); end
    endtask

    task automatic test_col_wrap();
        int w0;
        send_cmd(8'hB7);
        send_cmd(8'h0F);
        send_cmd(8'h17);
        tests++; if (col !== 7'd127) begin fails++; $display("FAIL wrap_col_pre: got %0d, required 127", col); end
        w0 = we_cnt;
        send_data(8'h11);
        send_data(8'h22);
        tests++; if (we_cnt - w0 !== 2) begin fails++; $display("FAIL wrap_we_count: got %0d, required 2", we_cnt - w0); end
        else begin
            tests++; if (wa_q[w0] !== 10'd1023 || wd_q[w0] !== 8'h11)
                begin fails++; $display("FAIL wrap_first: addr %0d data %0h, required 1023 11", wa_q[w0], wd_q[w0]); end
            tests++; if (wa_q[w0+1] !== 10'd896 || wd_q[w0+1] !== 8'h22)
                begin fails++; $display("FAIL wrap_second: addr %0d data %0h, required 896 22", wa_q[w0+1], wd_q[w0+1]); end
        end
        tests++; if (page !== 3'd7 || col !== 7'd1) begin fails++; $display("FAIL wrap_ptrs: page %0d col %0d, required 7 1", page, col); end
    endtask

    task automatic test_frame_err();
        logic e, l;
        int f0, w0, c0;
        f0 = fe_cnt; w0 = we_cnt; c0 = cmd_cnt;
        send_bits(8'hC8, 5, 1'b1, 4, 1'b0, e, l);
        spi_cs_n = 1'b1;
        settle();
        tests++; if (fe_cnt - f0 !== 1) begin fails++; $display("FAIL ferr_pulse: pulses %0d, required 1", fe_cnt - f0); end
        tests++; if (we_cnt !== w0 || cmd_cnt !== c0) begin fails++; $display("FAIL ferr_no_strobe: we %0d cmd %0d, required 0 0", we_cnt - w0, cmd_cnt - c0); end
        tests++; if (byte_count !== 16'(exp_bc)) begin fails++; $display("FAIL ferr_byte_count: got %0d, required %0d", byte_count, exp_bc); end
        spi_cs_n = 1'b0;
        settle();
        send_cmd(8'hAE);
        tests++; if (display_on !== 1'b0 || cmd_byte !== 8'hAE)
            begin fails++; $display("FAIL ferr_recover: disp %0b cmd %0h, required 0 ae", display_on, cmd_byte); end
        tests++; if (fe_cnt - f0 !== 1) begin fails++; $display("FAIL ferr_recover_pulse: pulses %0d, required 1", fe_cnt - f0); end
    endtask

    task automatic test_cs_simultaneous();
        logic e, l;
        int f0, w0;
        f0 = fe_cnt; w0 = we_cnt;
        send_bits(8'h5A, 8, 1'b1, 4, 1'b1, e, l);
        exp_bc++;
        settle();
        tests++; if (fe_cnt !== f0) begin fails++; $display("FAIL sim_frame_err: pulses %0d, required 0", fe_cnt - f0); end
        tests++; if (we_cnt - w0 !== 1) begin fails++; $display("FAIL sim_we_count: got %0d, required 1", we_cnt - w0); end
        else begin
            tests++; if (wa_q[w0] !== 10'd897 || wd_q[w0] !== 8'h5A)
                begin fails++; $display("FAIL sim_write: addr %0d data %0h, required 897 5a", wa_q[w0], wd_q[w0]); end
        end
        tests++; if (col !== 7'd2 || byte_count !== 16'(exp_bc))
            begin fails++; $display("FAIL sim_state: col %0d bc %0d, required 2 %0d", col, byte_count, exp_bc); end
        spi_cs_n = 1'b0;
        settle();
    endtask

    task automatic test_back_to_back();
        logic e, l;
        int w0, bad_lat, bad_wr;
        logic [15:0] bc0;
        send_cmd(8'hB0);
        send_cmd(8'h00);
        send_cmd(8'h10);
        w0 = we_cnt; bc0 = byte_count; bad_lat = 0; bad_wr = 0;
        for (int i = 0; i < 1024; i++) begin
            send_bits(i[7:0], 8, 1'b1, 3, 1'b0, e, l);
            exp_bc++;
            if (!(e === 1'b0 && l === 1'b1)) bad_lat++;
        end
        settle();
        tests++; if (we_cnt - w0 !== 1024) begin fails++; $display("FAIL b2b_we_count: got %0d, required 1024", we_cnt - w0); end
        else begin
            for (int k = 0; k < 1024; k++)
                if (wa_q[w0+k] !== 10'(k % 128) || wd_q[w0+k] !== 8'(k)) bad_wr++;
            tests++; if (bad_wr !== 0) begin fails++; $display("FAIL b2b_writes: %0d wrong, required 0", bad_wr); end
        end
        tests++; if (bad_lat !== 0) begin fails++; $display("FAIL b2b_latency: %0d bytes off third edge, required 0", bad_lat); end
        tests++; if (byte_count - bc0 !== 16'd1024) begin fails++; $display("FAIL b2b_byte_delta: got %0d, required 1024", byte_count - bc0); end
        tests++; if (byte_count !== 16'(exp_bc)) begin fails++; $display("FAIL b2b_byte_count: got %0d, required %0d", byte_count, exp_bc); end
        tests++; if (page !== 3'd0 || col !== 7'd0) begin fails++; $display("FAIL b2b_ptrs: page %0d col %0d, required 0 0", page, col); end
    endtask

    initial begin
        test_reset();
        test_addressing();
        test_misc_cmds();
        test_col_wrap();
        test_frame_err();
        test_cs_simultaneous();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_oled_receiver.md
Name: spi_oled_receiver

Overview:
- SPI slave receive end of the OLED link: models the SSD1306-style display controller that the SPI master, OLED init and OLED draw path talk to.
- Oversamples spi_clk/spi_mosi/spi_cs_n/spi_dc on the system clock and assembles MSB-first bytes.
- Decodes command bytes (page, column and display-on/off subset) and writes data bytes into an external GDDRAM port using page addressing mode.
- Used as the display model in OLED benches and as the checker front end for frame-content comparison.

Parameters:
- COLS, 128, columns per page; column counter wraps at COLS-1.
- PAGES, 8, number of pages; page field is 3 bits.
- ADDR_W, 10, GDDRAM address width; ram_addr = page*COLS + col.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- spi_clk  in  1  serial clock from master; mode 0, sampled on rising edge; asynchronous to clk.
- spi_mosi  in  1  serial data, MSB first.
- spi_cs_n  in  1  chip select, active low.
- spi_dc  in  1  0 = command byte, 1 = data byte; sampled with bit 0 (8th bit).
- ram_we  out  1  one-clk write strobe for a data byte.
- ram_addr  out  ADDR_W  write address.
- ram_wdata  out  8  write data.
- cmd_valid  out  1  one-clk strobe per received command byte.
- cmd_byte  out  8  last command byte; held until the next command byte.
- display_on  out  1  1 after 0xAF, 0 after 0xAE.
- page  out  3  current page pointer.
- col  out  7  current column pointer.
- frame_err  out  1  one-clk strobe when cs_n rises with a partial byte.
- byte_count  out  16  total bytes accepted, both commands and data; wraps at 0xFFFF->0.

Behaviour:
- Reset values: all outputs 0, and bit counter, shift register and synchroniser flops cleared. Reset mid-byte discards the partial byte without asserting frame_err.
- Input synchronisation:
  - spi_clk, spi_mosi, spi_dc and spi_cs_n each pass through 2 flops (s1→s2). A third flop on spi_clk gives the previous value.
  - rise = sclk_s2 & ~sclk_s3. cs_rise is detected the same way on cs_n.
- Input requirement: spi_clk high and low phases each ≥3 clk periods. Behaviour is undefined otherwise.
- Shift, when cs_n_s2 == 0 and rise:
  - shreg <= {shreg[6:0], mosi_s2}, bit_cnt <= bit_cnt+1.
  - On the 8th rise (bit_cnt == 7), the byte completes with dc latched from dc_s2, bit_cnt returns to 0, and exactly one result strobe is registered.
- Latency: a strobe (ram_we or cmd_valid) is high in the cycle following the clk edge that shifts bit 0. That is the 3rd clk edge after raw spi_clk is first sampled high.
- Rises with cs_n_s2 == 1 are ignored.
- cs_rise with bit_cnt != 0: pulse frame_err, set bit_cnt to 0, drop the byte and leave byte_count unchanged.
- cs_rise with bit_cnt == 0: no action.
- Command decode, dc = 0. cmd_valid pulses and cmd_byte updates for every command byte, then:
  - 0xB0-0xB7: page <= byte[2:0].
  - 0x00-0x0F: col[3:0] <= byte[3:0].
  - 0x10-0x17: col[6:4] <= byte[2:0].
  - 0x18-0x1F: upper nibble ignored, cmd_valid still pulses.
  - 0xAE / 0xAF: display_on <= 0 / 1.
  - Any other command: cmd_valid only, no state change. Multi-byte command arguments are not tracked; they decode as independent bytes.
- Data write, dc = 1:
  - ram_we = 1 for one clk with ram_addr = page*COLS + col (pre-increment value) and ram_wdata = byte.
  - Same edge: col <= (col == COLS-1) ? 0 : col+1. Page never changes (page addressing mode wrap).
- byte_count increments on each completed byte, command or data, in the same cycle as the strobe.
- Simultaneous cs_rise and 8th rise in the same clk cycle: the byte completes normally and frame_err is not asserted.
- ram_addr and ram_wdata hold their last values when ram_we = 0.

Test Plan:
- Reset: hold reset_n low 1000 ns mid-transfer, release → all outputs 0, no strobes. Send cmd 0xAF → cmd_valid = 1 once, cmd_byte = 0xAF, display_on = 1, byte_count = 1.
- Addressing: send cmds 0xB3, 0x05, 0x12 then data 0xA5 → page = 3, col = 0x25 before the write; ram_we once with ram_addr = 3*128+37 = 421 and ram_wdata = 0xA5; col = 38 after.
- Column wrap: page 7, col 127, send data 0x11, 0x22 → writes at addr 1023 then addr 896; page stays 7; col = 1.
- Framing error: assert cs_n low, send 5 bits, raise cs_n → frame_err = 1 for one clk, no ram_we or cmd_valid, byte_count unchanged; next full byte 0xAE decodes correctly and display_on = 0.
- Latency and spacing: spi_clk half period 3 clk with continuous data bytes → exactly one ram_we per byte, asserted on the 3rd clk edge after the raw 8th spi_clk rise; no missed or extra bytes over 1024 data bytes; byte_count = 1024.
- Integration: connect to SPI master + OLED init + OLED draw → command stream completes with display_on = 1, and a full 8×128 frame is written with every address 0-1023 receiving ram_we.
